// File: rtl/muls_accum_if.sv
// Bus bundle for muls_accum: multiplier product input, run control and result outputs.
// master = producer/consumer side, slave = the accumulator.
interface muls_accum_if #(
    parameter int ACC_WIDTH = 8,
    parameter int CNT_WIDTH = 4
);
    logic [3:0]                  p;
    logic                        s;
    logic                        rdy;
    logic                        start;
    logic [CNT_WIDTH-1:0]        n_terms;
    logic                        ack;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        acc_valid;
    logic                        busy;
    logic                        ovf;

    modport master (
        output p, s, rdy, start, n_terms, ack,
        input  acc, acc_valid, busy, ovf
    );

    modport slave (
        input  p, s, rdy, start, n_terms, ack,
        output acc, acc_valid, busy, ovf
    );
endinterface

// File: rtl/muls_accum.sv
// Signed accumulator of sign/magnitude products over a counted run of rdy edges.
// Define MULS_ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
module muls_accum #(
    parameter int ACC_WIDTH = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    muls_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                      state, state_next;
    logic signed [ACC_WIDTH-1:0] acc_r, acc_next;
    logic                        ovf_r, ovf_next;
    logic [CNT_WIDTH-1:0]        count, count_next;
    logic                        rdy_q;
    logic                        busy_r;
    logic                        valid_r;

    logic                        term_evt;
    logic signed [ACC_WIDTH-1:0] mag;
    logic signed [ACC_WIDTH-1:0] term;
    logic signed [ACC_WIDTH:0]   sum_ext;
    logic                        sum_ovf;
    logic signed [ACC_WIDTH-1:0] sum_val;

    assign term_evt = bus.rdy & ~rdy_q;
    // A negative zero magnitude negates to zero, so it needs no special case.
    assign mag      = {{(ACC_WIDTH-4){1'b0}}, bus.p};
    assign term     = bus.s ? -mag : mag;
    assign sum_ext  = {acc_r[ACC_WIDTH-1], acc_r} + {term[ACC_WIDTH-1], term};
    assign sum_ovf  = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];

`ifdef MULS_ACCUM_SATURATE_EN
    assign sum_val = sum_ovf ? (sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                             : sum_ext[ACC_WIDTH-1:0];
`else
    assign sum_val = sum_ext[ACC_WIDTH-1:0];
`endif

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc_r;
        ovf_next   = ovf_r;
        count_next = count;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    count_next = bus.n_terms;
                end
            end
            RUN: begin
                if (term_evt) begin
                    acc_next   = sum_val;
                    ovf_next   = ovf_r | sum_ovf;
                    count_next = count - CNT_WIDTH'(1);
                    // A loaded count of zero wraps through all 2^CNT_WIDTH values before reaching one.
                    if (count == CNT_WIDTH'(1)) state_next = DONE;
                end
            end
            DONE: begin
                if (bus.ack && bus.start) begin
                    state_next = RUN;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    count_next = bus.n_terms;
                end else if (bus.ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            count   <= '0;
            rdy_q   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_next;
            acc_r   <= acc_next;
            ovf_r   <= ovf_next;
            count   <= count_next;
            rdy_q   <= bus.rdy;
            busy_r  <= (state_next == RUN);
            valid_r <= (state_next == DONE);
        end
    end

    assign bus.acc       = acc_r;
    assign bus.ovf       = ovf_r;
    assign bus.busy      = busy_r;
    assign bus.acc_valid = valid_r;
endmodule

// File: tb/tb_muls_accum.sv
// Self-checking bench for muls_accum: scoreboard of expected run results plus directed checks.
// Follows MULS_ACCUM_SATURATE_EN to choose the saturating or wrapping reference model.
module tb_muls_accum;
    localparam int AW   = 8;
    localparam int CW   = 4;
    localparam int MAXV = (1 << (AW - 1)) - 1;
    localparam int MINV = -(1 << (AW - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muls_accum_if #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    muls_accum #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_acc;
    int   m_ovf;
    logic av_prev = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int acc_s();
        return int'($signed(bus.acc));
    endfunction

    task automatic model_start();
        m_acc = 0;
        m_ovf = 0;
    endtask

    task automatic model_add(input int v);
        int t;
        t = m_acc + v;
        if (t > MAXV || t < MINV) begin
            m_ovf = 1;
`ifdef MULS_ACCUM_SATURATE_EN
            t = (t > MAXV) ? MAXV : MINV;
`else
            t = (t > MAXV) ? t - (1 << AW) : t + (1 << AW);
`endif
        end
        m_acc = t;
    endtask

    task automatic model_push();
        exp_t e;
        e.acc = m_acc;
        e.ovf = m_ovf;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        bus.start   = 1'b1;
        bus.n_terms = CW'(n);
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic term(input logic [3:0] pv, input logic sv);
        bus.p   = pv;
        bus.s   = sv;
        bus.rdy = 1'b1;
        tick();
        bus.rdy = 1'b0;
        tick();
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    // Compare each completed result against the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (bus.acc_valid && !av_prev) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_acc", acc_s(), mon_e.acc);
                check("sb_ovf", int'(bus.ovf), mon_e.ovf);
            end
        end
        av_prev = bus.acc_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p       = '0;
        bus.s       = 1'b0;
        bus.rdy     = 1'b0;
        bus.start   = 1'b0;
        bus.n_terms = '0;
        bus.ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc_s(), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.acc_valid), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        rst_n = 1'b1;
        tick();

        // Basic run: +9, -4, +2 -> 7.
        model_start(); model_add(9); model_add(-4); model_add(2); model_push();
        start_run(3);
        check("a_busy", int'(bus.busy), 1);
        check("a_acc0", acc_s(), 0);
        term(4'd9, 1'b0);
        check("a_acc1", acc_s(), 9);
        term(4'd4, 1'b1);
        check("a_acc2", acc_s(), 5);
        bus.p = 4'd2; bus.s = 1'b0; bus.rdy = 1'b1;
        tick();
        check("a_valid_edge", int'(bus.acc_valid), 1);
        check("a_acc3", acc_s(), 7);
        check("a_ovf", int'(bus.ovf), 0);
        bus.rdy = 1'b0;
        tick();
        term(4'd5, 1'b0);
        check("done_term_ignored", acc_s(), 7);
        do_ack();
        check("ack_valid", int'(bus.acc_valid), 0);
        check("ack_busy", int'(bus.busy), 0);
        check("ack_acc_kept", acc_s(), 7);
        term(4'd3, 1'b0);
        check("idle_term_ignored", acc_s(), 7);

        // Sixteen +9 terms via n_terms = 0.
        model_start();
        for (int i = 0; i < 16; i++) model_add(9);
        model_push();
        start_run(0);
        for (int i = 0; i < 15; i++) term(4'd9, 1'b0);
        check("b_busy_after15", int'(bus.busy), 1);
        term(4'd9, 1'b0);
        check("b_valid", int'(bus.acc_valid), 1);
        do_ack();

        // rdy held high counts once; start ignored while running.
        model_start(); model_add(1); model_add(2); model_push();
        start_run(2);
        bus.p = 4'd1; bus.s = 1'b0; bus.rdy = 1'b1;
        repeat (5) tick();
        bus.rdy = 1'b0;
        tick();
        check("held_acc", acc_s(), 1);
        check("held_busy", int'(bus.busy), 1);
        start_run(1);
        check("run_start_ignored", acc_s(), 1);
        term(4'd2, 1'b0);
        check("held_valid", int'(bus.acc_valid), 1);
        do_ack();

        // Negative zero leaves acc unchanged but consumes a term.
        model_start(); model_add(0); model_add(-4); model_push();
        start_run(2);
        term(4'd0, 1'b1);
        check("negzero_acc", acc_s(), 0);
        check("negzero_busy", int'(bus.busy), 1);
        term(4'd4, 1'b1);
        check("negzero_valid", int'(bus.acc_valid), 1);
        do_ack();

        // Ack and start together go straight into a new run.
        model_start(); model_add(5); model_push();
        model_start(); model_add(-3); model_push();
        start_run(1);
        term(4'd5, 1'b0);
        check("as_first_acc", acc_s(), 5);
        start_run(1);
        check("done_start_ignored", int'(bus.acc_valid), 1);
        bus.ack = 1'b1; bus.start = 1'b1; bus.n_terms = CW'(1);
        tick();
        bus.ack = 1'b0; bus.start = 1'b0;
        check("as_busy", int'(bus.busy), 1);
        check("as_acc_cleared", acc_s(), 0);
        check("as_valid_low", int'(bus.acc_valid), 0);
        term(4'd3, 1'b1);
        check("as_acc", acc_s(), -3);
        check("as_valid", int'(bus.acc_valid), 1);
        do_ack();

        // Reset mid-run abandons the run; rdy high at release is not an edge.
        start_run(4);
        term(4'd1, 1'b0);
        term(4'd1, 1'b0);
        bus.p = 4'd1; bus.rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", acc_s(), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_valid", int'(bus.acc_valid), 0);
        check("mid_rst_ovf", int'(bus.ovf), 0);
        tick();
        rst_n = 1'b1;
        start_run(1);
        tick();
        tick();
        check("rel_busy", int'(bus.busy), 1);
        check("rel_acc", acc_s(), 0);
        bus.rdy = 1'b0;
        tick();
        model_start(); model_add(6); model_push();
        term(4'd6, 1'b0);
        check("rel_valid", int'(bus.acc_valid), 1);
        do_ack();
        tick();

        check("sb_pending", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
